// File: rtl/pipe_control.sv
// pipe_control: control unit for the 5-stage RV32I pipeline.
// Decodes the IF/ID opcode, carries the control bundle through ID/EX, EX/MEM
// and MEM/WB, inserts load-use bubbles, squashes ID on a taken branch and
// drives the EX-stage forwarding selects.
// Optional feature: define PIPE_CONTROL_JAL_EN to decode JAL (1101111).
module pipe_control #(
    parameter int REG_AW     = 5,
    parameter int LU_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [6:0]        opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              branch_taken,
    output logic              stall,
    output logic              ex_alusrc,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [1:0]        ex_aluop,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
`ifdef PIPE_CONTROL_JAL_EN
    localparam logic [6:0] OP_J  = 7'b1101111;
`endif

    // Value loaded into the 1-bit bubble counter on a fresh hazard.
    localparam logic LU_LOAD = (LU_BUBBLES == 2) ? 1'b1 : 1'b0;

    // Decoded ID-stage bundle
    logic              d_alusrc, d_branch, d_memread, d_memwrite;
    logic              d_regwrite, d_memtoreg, d_use1, d_use2;
    logic [1:0]        d_aluop;
    logic [REG_AW-1:0] d_rd, d_rs1, d_rs2;
`ifdef PIPE_CONTROL_JAL_EN
    logic              d_jump;
    logic              ex_jump_q;
`endif

    // ID/EX internal state
    logic              ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_use2;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    // EX/MEM internal state
    logic              mem_regwrite, mem_memtoreg;

    logic hz;
    logic cnt;

    // Opcode decode; invalid or unknown opcodes yield the all-zero NOP bundle.
    always_comb begin
        d_alusrc   = 1'b0;
        d_branch   = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_regwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_use1     = 1'b0;
        d_use2     = 1'b0;
        d_aluop    = 2'b00;
`ifdef PIPE_CONTROL_JAL_EN
        d_jump     = 1'b0;
`endif
        if (id_valid) begin
            case (opcode)
                OP_R:  begin d_regwrite = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1; end
                OP_I:  begin d_alusrc = 1'b1; d_aluop = 2'b11; d_regwrite = 1'b1; d_use1 = 1'b1; end
                OP_LW: begin
                    d_alusrc   = 1'b1;
                    d_aluop    = 2'b10;
                    d_memread  = 1'b1;
                    d_memtoreg = 1'b1;
                    d_regwrite = 1'b1;
                    d_use1     = 1'b1;
                end
                OP_SW: begin d_alusrc = 1'b1; d_aluop = 2'b10; d_memwrite = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1; end
                OP_B:  begin d_branch = 1'b1; d_aluop = 2'b01; d_use1 = 1'b1; d_use2 = 1'b1; end
`ifdef PIPE_CONTROL_JAL_EN
                OP_J:  begin d_jump = 1'b1; d_regwrite = 1'b1; end
`endif
                default: ;
            endcase
        end
        // Unused register fields are zeroed so they can never match a
        // forwarding or hazard compare.
        d_rd  = d_regwrite ? id_rd  : '0;
        d_rs1 = d_use1     ? id_rs1 : '0;
        d_rs2 = d_use2     ? id_rs2 : '0;
    end

    // Load-use hazard detection and stall; a taken branch overrides the stall.
    always_comb begin
        hz = id_valid && ex_memread && (ex_rd != '0) &&
             ((d_use1 && (id_rs1 == ex_rd)) || (d_use2 && (id_rs2 == ex_rd)));
        stall = (hz || cnt) && !branch_taken;
    end

    // Stage registers: ID/EX takes a bubble on flush or stall, later stages always advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_alusrc    <= 1'b0;
            ex_branch    <= 1'b0;
            ex_aluop     <= 2'b00;
            ex_memread   <= 1'b0;
            ex_memwrite  <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memtoreg  <= 1'b0;
            ex_use2      <= 1'b0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
`ifdef PIPE_CONTROL_JAL_EN
            ex_jump_q    <= 1'b0;
`endif
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_rd       <= '0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            if (branch_taken || stall) begin
                ex_alusrc   <= 1'b0;
                ex_branch   <= 1'b0;
                ex_aluop    <= 2'b00;
                ex_memread  <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memtoreg <= 1'b0;
                ex_use2     <= 1'b0;
                ex_rd       <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
`ifdef PIPE_CONTROL_JAL_EN
                ex_jump_q   <= 1'b0;
`endif
            end else begin
                ex_alusrc   <= d_alusrc;
                ex_branch   <= d_branch;
                ex_aluop    <= d_aluop;
                ex_memread  <= d_memread;
                ex_memwrite <= d_memwrite;
                ex_regwrite <= d_regwrite;
                ex_memtoreg <= d_memtoreg;
                ex_use2     <= d_use2;
                ex_rd       <= d_rd;
                ex_rs1      <= d_rs1;
                ex_rs2      <= d_rs2;
`ifdef PIPE_CONTROL_JAL_EN
                ex_jump_q   <= d_jump;
`endif
            end
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_regwrite <= ex_regwrite;
            mem_memtoreg <= ex_memtoreg;
            mem_rd       <= ex_rd;
            wb_regwrite  <= mem_regwrite;
            wb_memtoreg  <= mem_memtoreg;
            wb_rd        <= mem_rd;
        end
    end

`ifdef PIPE_CONTROL_JAL_EN
    assign ex_jump = ex_jump_q;
`else
    assign ex_jump = 1'b0;
`endif

    // Bubble down-counter: loads on a fresh hazard, counts to zero, cleared by flush.
    always_ff @(posedge clk) begin
        if (rst || branch_taken) begin
            cnt <= 1'b0;
        end else if (cnt) begin
            cnt <= 1'b0;
        end else if (hz) begin
            cnt <= LU_LOAD;
        end
    end

    // EX operand forwarding; EX/MEM beats MEM/WB, x0 never forwards.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
            forward_a = 2'b10;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
            forward_a = 2'b01;
        end
        if (ex_use2) begin
            if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
                forward_b = 2'b10;
            end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
                forward_b = 2'b01;
            end
        end
    end

endmodule
